// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: byte-serial load/run/drain sequencer for the 3x3 matrix multiplier.
// Define MATRIX_SEQ_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT cycles and raise a sticky err.
module matrix_seq_ctrl #(
  parameter int W       = 8,
  parameter int N_IN    = 18,
  parameter int N_OUT   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [9*W-1:0] mat_a,
  output logic [9*W-1:0] mat_b,
  output logic           mat_load,
  input  logic           mat_done,
  input  logic [9*W-1:0] mat_out,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic           busy,
  output logic           err
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, WAIT = 3'd3, DRAIN = 3'd4;
  logic [2:0] state;
  logic [4:0] cnt;
  logic [3:0] ocnt;
  logic [N_IN*W-1:0] ops;
  logic [N_OUT*W-1:0] res;
  logic in_fire, out_fire, in_last, out_last, timeout;
  assign in_ready  = state == IDLE || state == LOAD;
  assign mat_load  = state == START;
  assign out_valid = state == DRAIN;
  assign busy      = state != IDLE;
  assign mat_a     = ops[9*W-1:0];
  assign mat_b     = ops[18*W-1:9*W];
  assign out_data  = res[W*ocnt +: W];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_last   = cnt == 5'(N_IN - 1);
  assign out_last  = ocnt == 4'(N_OUT - 1);
`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  assign timeout = state == WAIT && !mat_done && wcnt == TW'(TIMEOUT - 1);
  // wcnt idles at zero outside WAIT, so it is already clear on entry
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      wcnt <= state == WAIT ? wcnt + TW'(1) : '0;
      if (timeout) err <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      ocnt  <= '0;
      ops   <= '0;
      res   <= '0;
    end else begin
      if (in_fire) begin
        ops[W*cnt +: W] <= in_data;
        cnt   <= in_last ? '0 : cnt + 5'd1;
        state <= in_last ? START : LOAD;
      end
      if (state == START) state <= WAIT;
      if (state == WAIT && mat_done) begin
        res   <= mat_out;
        ocnt  <= '0;
        state <= DRAIN;
      end
      if (timeout) state <= IDLE;
      if (out_fire) begin
        ocnt <= out_last ? '0 : ocnt + 4'd1;
        if (out_last) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// tb_matrix_seq_ctrl: scoreboard bench with a stub multiplier, directed and random jobs.
module tb_matrix_seq_ctrl;
  logic clk = 0, rstn = 0, in_valid = 0, out_ready = 1, stub_done = 0, glitch = 0;
  logic [7:0] in_data = '0;
  logic [71:0] stub_out = '0, stub_v, mat_a, mat_b, mat_out;
  logic in_ready, mat_load, mat_done, out_valid, busy, err;
  logic [7:0] out_data, stall_data;
  logic [143:0] e_ops;
  int total = 0, bad = 0, cyc = 0, stub_mode = 0, or_mode = 0, ph = 0;
  int acc = 0, oc = 0, load_cyc = 0, done_cyc = -1;
  bit inflight = 0, load_due = 0, started = 0, stalled = 0, ir_due = 0, err_prev = 0;
  logic [7:0] job [18];
  logic [143:0] exp_ops [$];
  logic [7:0] exp_res [$];

  assign mat_done = stub_done | glitch;
  assign mat_out  = glitch ? {9{8'hEE}} : stub_out;

  matrix_seq_ctrl dut (
    .clk(clk), .Reset(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .mat_load(mat_load), .mat_done(mat_done), .mat_out(mat_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // 3x3 product of row-major byte matrices, truncated to 8 bits per element
  function automatic logic [71:0] prod(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] r;
    logic [7:0] s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s = s + 8'(a[8*(3*i+k) +: 8] * b[8*(3*k+j) +: 8]);
        r[8*(3*i+j) +: 8] = s;
      end
    return r;
  endfunction

  function automatic logic [71:0] fixed_pat();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'h10 + 8'(k);
    return r;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_ctl"}, {in_ready, mat_load, out_valid, busy, err}, 5'b10000);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_operands"}, {mat_b, mat_a}, 0);
  endtask

  task automatic send(input int n, input bit gaps);
    logic [143:0] o;
    logic [71:0] r;
    int w;
    if (n == 18) begin
      for (int k = 0; k < 18; k++) o[8*k +: 8] = job[k];
      exp_ops.push_back(o);
      if (stub_mode != 2) begin
        r = stub_mode == 1 ? fixed_pat() : prod(o[71:0], o[143:72]);
        for (int k = 0; k < 9; k++) exp_res.push_back(r[8*k +: 8]);
      end
    end
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1;
      in_data = job[i];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (w >= 200) fail("accept_timeout");
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_job();
    int w = 0;
    while ((inflight || load_due) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (inflight) fail("job_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic rand_job();
    foreach (job[k]) job[k] = 8'($urandom);
  endtask

  // stub multiplier: Done one cycle wide, 5 cycles after Load
  initial forever begin
    @(negedge clk);
    if (rstn && mat_load && stub_mode != 2) begin
      stub_v = stub_mode == 1 ? fixed_pat() : prod(mat_a, mat_b);
      repeat (5) @(posedge clk);
      #1;
      stub_done = 1;
      stub_out = stub_v;
      @(posedge clk);
      #1;
      stub_done = 0;
      stub_out = 72'({$urandom, $urandom, $urandom});
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (or_mode == 0) out_ready = 1;
    else if (or_mode == 1) begin
      out_ready = ph == 0;
      ph = (ph + 1) % 3;
    end else out_ready = 1'($urandom_range(0, 1));
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rstn) begin
      acc = 0; oc = 0; inflight = 0; load_due = 0; started = 0; stalled = 0; ir_due = 0;
    end else begin
      if (ir_due) begin
        chk("ready_after_drain", {in_ready, busy, out_valid}, 3'b100);
        ir_due = 0;
      end
      if (mat_load || load_due) begin
        chk("load_pulse", mat_load, load_due);
        if (load_due) begin
          load_cyc = cyc;
          if (exp_ops.size() == 0) fail("load_without_job");
          else begin
            e_ops = exp_ops.pop_front();
            chk("mat_a", mat_a, e_ops[71:0]);
            chk("mat_b", mat_b, e_ops[143:72]);
          end
          load_due = 0;
        end
      end
`ifdef MATRIX_SEQ_TIMEOUT_EN
      if (err && !err_prev) inflight = 0;
`endif
      if (inflight) chk("in_ready_busy", in_ready, 0);
      if (in_valid && in_ready) begin
        acc++;
        if (acc == 18) begin
          acc = 0; oc = 0; load_due = 1; inflight = 1; started = 0; done_cyc = -1;
        end
      end
      if (inflight && !started && mat_done && done_cyc < 0) done_cyc = cyc;
      if (stalled && out_valid) chk("stall_hold", out_data, stall_data);
      if (out_valid && inflight && !started) begin
        chk("done_to_valid", 144'(cyc - done_cyc), 1);
        started = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) fail("unexpected_output");
        else chk("out_data", out_data, exp_res.pop_front());
        oc++;
        if (oc == 9) begin
          oc = 0; ir_due = 1; inflight = 0;
        end
      end
      stalled = out_valid && !out_ready;
      stall_data = out_data;
    end
    err_prev = err;
  end

  initial begin
    int w;
    stub_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_check("por");
    rstn = 1;
    @(posedge clk);
    #1;
    rand_job();
    send(7, 0);
    chk("busy_in_load", busy, 1);
    rstn = 0;
    #1;
    reset_check("mid_load");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    foreach (job[k]) job[k] = k < 9 ? 8'h20 : 8'h28;
    send(18, 0);
    wait_job();
    or_mode = 1;
    send(18, 0);
    wait_job();
    stub_mode = 0;
    rand_job();
    fork
      send(18, 1);
      begin
        repeat (8) @(posedge clk);
        #1 glitch = 1;
        @(posedge clk);
        #1 glitch = 0;
      end
    join
    in_valid = 1;
    in_data = 8'hAA;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 0;
    @(posedge clk);
    #1 glitch = 1;
    @(posedge clk);
    #1 glitch = 0;
    wait_job();
    or_mode = 2;
    repeat (6) begin
      rand_job();
      send(18, 1);
      wait_job();
    end
`ifdef MATRIX_SEQ_TIMEOUT_EN
    stub_mode = 2;
    or_mode = 0;
    rand_job();
    send(18, 0);
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("timeout_len", 144'(cyc - load_cyc), 65);
    chk("err_set", err, 1);
    @(posedge clk);
    #1;
    stub_mode = 0;
    or_mode = 2;
    rand_job();
    send(18, 1);
    wait_job();
    chk("err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif
    repeat (3) @(posedge clk);
    if (exp_res.size() != 0 || exp_ops.size() != 0) fail("leftover_expectations");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_seq_ctrl.md
Name: matrix_seq_ctrl

Overview:
- Sequencer for the 3x3 8-bit matrix multiplier datapath (`matrix`, ports clk/A/B/Out/Reset/Load/Done).
- Accepts the 18 operand bytes as a serial valid/ready byte stream, registers them, pulses the multiplier's Load and waits for its Done.
- Captures the 9 results and streams them back out byte-serially.
- Sits between the board-level byte I/O and `matrix`, so top level needs no 144 parallel operand wires.

Parameters:
- W, 8, element width in bits (matches multiplier).
- N_IN, 18, operand bytes per job (9 A, then 9 B).
- N_OUT, 9, result bytes per job.
- TIMEOUT, 64, max cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset; all state cleared while low.
- in_valid  in  1  operand byte valid.
- in_data  in  W  operand byte; order A00,A01,A02,A10..A22,B00..B22 (row-major).
- in_ready  out  1  controller accepts operand byte.
- mat_a  out  9*W  A operands; Aij at bits [W*(3i+j) +: W].
- mat_b  out  9*W  B operands, same packing.
- mat_load  out  1  one-cycle Load pulse to multiplier.
- mat_done  in  1  multiplier Done.
- mat_out  in  9*W  multiplier Out00..Out22, same packing.
- out_valid  out  1  result byte valid.
- out_data  out  W  result byte; order Out00..Out22 row-major.
- out_ready  in  1  downstream accepts result byte.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag (optional feature only; else tied 0).

Behaviour:
- Reset values: state=IDLE, counters=0, mat_a/mat_b=0, result regs=0, in_ready=1, mat_load=0, out_valid=0, out_data=0, busy=0, err=0.
- Handshake: transfer when valid&ready on a rising edge. Producer holds data while valid is high and ready is low.
- States:
  - IDLE: in_ready=1. A transfer writes element 0, sets cnt=1 and moves to LOAD.
  - LOAD: in_ready=1. Each transfer writes element cnt and increments cnt. The transfer at cnt=N_IN-1 moves to START.
  - START: mat_load=1 for exactly this one cycle, in_ready=0. Next state WAIT.
  - WAIT: in_ready=0. Samples mat_done. When mat_done=1, registers mat_out into the result regs on that same edge, sets ocnt=0 and moves to DRAIN.
  - DRAIN: out_valid=1, out_data=result[ocnt]. On a transfer ocnt increments. The transfer at ocnt=N_OUT-1 moves to IDLE.
- Output path is registered; in_ready and out_valid are decodes of registered state.
- Latency:
  - Last operand accepted to mat_load high: 1 cycle.
  - mat_done high to first out_valid: 1 cycle.
  - Last result accepted to in_ready high: 1 cycle (state is IDLE).
- mat_a/mat_b hold stable from START until the next job's first write.
- mat_done is ignored in any state other than WAIT; a Done already high on entry to WAIT is accepted in the first WAIT cycle.
- out_valid stalled by out_ready=0: out_data and ocnt hold.
- No input is accepted during START/WAIT/DRAIN; no back-to-back overlap of jobs.
- Reset low mid-job (any state): immediate return to reset values, partial operands discarded. mat_load drops asynchronously.
- No arithmetic beyond the counters: cnt is 5 bits (0..17), ocnt is 4 bits (0..8). Neither counter ever wraps past its terminal value.

Optional Feature:
- Macro: MATRIX_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without mat_done.
  - If it reaches TIMEOUT, the FSM returns to IDLE, result regs are not updated, no DRAIN occurs and err is set.
  - err is sticky until Reset. Being in IDLE still accepts new jobs.
- Undefined: no counter; WAIT waits indefinitely; err constant 0.

Test Plan:
- Reset low 2 cycles mid-LOAD (after 7 bytes), then release.
  - Expect all outputs at reset values and in_ready=1.
  - Next 18 bytes form a fresh job, with A00 taken from the first byte after release.
- Stream 18 bytes: A bytes = 0x20, B bytes = 0x28, in_valid held high.
  - Expect mat_a = {9{0x20}} and mat_b = {9{0x28}}.
  - Expect a single mat_load pulse exactly 1 cycle after the 18th accept.
- Bench stub multiplier asserts mat_done 5 cycles after Load, with Outij = 0x10+3i+j.
  - Expect out_data sequence 0x10..0x18 in order.
  - First out_valid 1 cycle after mat_done.
- Same job with out_ready toggling 1,0,0,1...
  - Expect out_data to hold during stalls and exactly 9 transfers.
  - Expect in_ready high the cycle after the last transfer.
- mat_done pulsed during LOAD and DRAIN.
  - Expect it ignored: no state change, no result overwrite.
  - in_valid during WAIT is never accepted (in_ready=0).
- With MATRIX_SEQ_TIMEOUT_EN and TIMEOUT=64, stub never asserts Done.
  - Expect return to IDLE exactly 64 WAIT cycles after entering WAIT.
  - Expect err=1 with no out_valid; err stays 1 through a following successful job.
